// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction-memory request/response bus between the fetch unit and imem.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - non-pipelined IF stage: owns the PC, one imem fetch in flight, redirect/stall handling.
// Optional IF_ALIGN_CHECK_EN: misaligned redirect targets are rejected and flagged on if_addr_err.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  if_fetch_unit_if.master       imem,
  output logic [31:0]           IF_pc_4,
  output logic [31:0]           IF_inst,
  output logic                  IF_valid,
  output logic                  fetch_busy
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic                  if_addr_err
`endif
);

  localparam logic [1:0] REQ  = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] DROP = 2'd3;

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        buf_valid_q, buf_valid_d;
  logic [1:0]  state_q, state_d;
  logic        redirect_ok;
  logic        err_lock;

`ifdef IF_ALIGN_CHECK_EN
  logic addr_err_q, addr_err_d;
  logic redirect_bad;
  assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redirect_ok  = redirect_valid && !redirect_bad;
  assign err_lock     = addr_err_q;
  assign if_addr_err  = addr_err_q;
`else
  assign redirect_ok  = redirect_valid;
  assign err_lock     = 1'b0;
`endif

  always_comb begin
    pc_d        = pc_q;
    inst_buf_d  = inst_buf_q;
    buf_valid_d = buf_valid_q;
    state_d     = state_q;
    case (state_q)
      REQ:  if (imem.imem_ready) state_d = WAIT;
      WAIT: if (imem.imem_rvalid) begin
              inst_buf_d  = imem.imem_rdata;
              buf_valid_d = 1'b1;
              state_d     = HOLD;
            end
      HOLD: if (!stall && !err_lock) begin
              pc_d        = pc_q + 32'd4;
              buf_valid_d = 1'b0;
              state_d     = REQ;
            end
      default: if (imem.imem_rvalid) state_d = REQ;
    endcase
    // A redirect beats stall; a response landing in the same cycle closes the old fetch.
    if (redirect_ok) begin
      pc_d        = redirect_pc & ~32'h3;
      buf_valid_d = 1'b0;
      case (state_q)
        REQ:     state_d = imem.imem_ready ? DROP : REQ;
        HOLD:    state_d = REQ;
        default: state_d = imem.imem_rvalid ? REQ : DROP;
      endcase
    end
`ifdef IF_ALIGN_CHECK_EN
    addr_err_d = addr_err_q;
    if (redirect_ok) begin
      addr_err_d = 1'b0;
    end else if (redirect_bad) begin
      pc_d        = pc_q;
      buf_valid_d = 1'b0;
      state_d     = HOLD;
      addr_err_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      inst_buf_q  <= NOP_WORD;
      buf_valid_q <= 1'b0;
      state_q     <= REQ;
    end else begin
      pc_q        <= pc_d;
      inst_buf_q  <= inst_buf_d;
      buf_valid_q <= buf_valid_d;
      state_q     <= state_d;
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) addr_err_q <= 1'b0;
    else     addr_err_q <= addr_err_d;
  end
`endif

  assign imem.imem_req  = (state_q == REQ);
  assign imem.imem_addr = pc_q;
  assign IF_valid       = buf_valid_q && (state_q == HOLD);
  assign IF_inst        = IF_valid ? inst_buf_q : NOP_WORD;
  assign IF_pc_4        = pc_q + 32'd4;
  assign fetch_busy     = !IF_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit: memory model, program-order PC model, monitor.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] IF_pc_4, IF_inst;
  logic        IF_valid, fetch_busy;
`ifdef IF_ALIGN_CHECK_EN
  logic        if_addr_err;
  bit          exp_err = 1'b0;
`endif

  if_fetch_unit_if bus ();

  if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem(bus),
    .IF_pc_4(IF_pc_4), .IF_inst(IF_inst), .IF_valid(IF_valid), .fetch_busy(fetch_busy)
`ifdef IF_ALIGN_CHECK_EN
    , .if_addr_err(if_addr_err)
`endif
  );

  always #5 clk = ~clk;

  int          total = 0, bad = 0, consumed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] hs_q[$];
  logic [31:0] arch_pc;
  bit          mon_en = 1'b0;
  bit          pending = 1'b0;
  logic [31:0] paddr;
  int          cnt;
  int          rdy_pct = 100, dly_min = 0, dly_max = 0;
  bit          prev_wait = 1'b0;
  logic [31:0] prev_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h2408_0005;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: entered and left at a negedge. Drives memory + control, then advances the models.
  task automatic step(input bit r, input bit st, input bit rv, input logic [31:0] tgt);
    bit hs, rvl, v, renew;
    logic [31:0] a;
    v = (IF_valid === 1'b1);
    a = bus.imem_addr;
    if (mon_en && prev_wait) begin
      chk("req_held", {31'd0, bus.imem_req}, 32'd1);
      chk("addr_held", a, prev_addr);
    end
    rvl = pending && (cnt == 0);
    if (pending && cnt > 0) cnt--;
    bus.imem_rvalid = rvl;
    bus.imem_rdata  = rvl ? mem_word(paddr) : $urandom;
    bus.imem_ready  = !pending && ($urandom_range(99) < rdy_pct);
    hs = (bus.imem_req === 1'b1) && bus.imem_ready && !r;
    if (hs && mon_en) begin
      chk("fetch_addr", a, arch_pc);
      hs_q.push_back(a);
    end
    rst = r; stall = st; redirect_valid = rv; redirect_pc = tgt;
    prev_wait = !hs && (bus.imem_req === 1'b1) && !bus.imem_ready && !rv && !r;
    prev_addr = a;
    @(posedge clk);
    if (rvl || r) pending = 1'b0;
    if (hs) begin
      pending = 1'b1;
      paddr   = a;
      cnt     = $urandom_range(dly_max, dly_min);
    end
    renew = 1'b0;
    if (r) begin
      arch_pc = RESET_PC; renew = 1'b1; mon_en = 1'b1;
`ifdef IF_ALIGN_CHECK_EN
      exp_err = 1'b0;
`endif
    end else if (rv) begin
`ifdef IF_ALIGN_CHECK_EN
      if (tgt[1:0] != 2'b00) exp_err = 1'b1;
      else begin arch_pc = tgt; renew = 1'b1; exp_err = 1'b0; end
`else
      arch_pc = tgt & ~32'h3; renew = 1'b1;
`endif
    end else if (v && !st) begin
      arch_pc = arch_pc + 32'd4; renew = 1'b1; consumed++;
    end
    if (renew) begin
      exp_q.delete();
      exp_q.push_back(arch_pc);
    end
    @(negedge clk);
  endtask

  task automatic wait_for_valid(input bit st);
    for (int i = 0; i < 50 && IF_valid !== 1'b1; i++) step(1'b0, st, 1'b0, 32'd0);
    chk("wait_valid", {31'd0, IF_valid}, 32'd1);
  endtask

  task automatic wait_for_fetch();
    hs_q.delete();
    for (int i = 0; i < 50 && hs_q.size() == 0; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("wait_fetch", 32'(hs_q.size()), 32'd1);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (IF_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
          end else begin
            chk("sb_inst", IF_inst, mem_word(exp_q[0]));
            chk("sb_pc_4", IF_pc_4, exp_q[0] + 32'd4);
          end
          chk("sb_busy_lo", {31'd0, fetch_busy}, 32'd0);
        end else begin
          chk("sb_nop", IF_inst, NOP_WORD);
          chk("sb_busy_hi", {31'd0, fetch_busy}, 32'd1);
        end
`ifdef IF_ALIGN_CHECK_EN
        chk("sb_addr_err", {31'd0, if_addr_err}, {31'd0, exp_err});
`endif
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [31:0] t, inst0, pc40;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);

    chk("rst_req", {31'd0, bus.imem_req}, 32'd1);
    chk("rst_addr", bus.imem_addr, RESET_PC);
    chk("rst_valid", {31'd0, IF_valid}, 32'd0);
    chk("rst_inst", IF_inst, NOP_WORD);
    chk("rst_pc_4", IF_pc_4, RESET_PC + 32'd4);
    chk("rst_busy", {31'd0, fetch_busy}, 32'd1);

    hs_q.delete();
    repeat (9) step(1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++)
      chk("seq_addr", (i < hs_q.size()) ? hs_q[i] : 32'hFFFF_FFFF, 32'(i * 4));

    wait_for_valid(1'b1);
    inst0 = IF_inst;
    pc40  = IF_pc_4;
    chk("stall_first", inst0, mem_word(arch_pc));
    repeat (3) begin
      step(1'b0, 1'b1, 1'b0, 32'd0);
      chk("stall_inst", IF_inst, inst0);
      chk("stall_pc_4", IF_pc_4, pc40);
      chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
    end

    dly_min = 2; dly_max = 2;
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("in_wait", {31'd0, pending}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0100);
    wait_for_fetch();
    chk("redir_wait_addr", (hs_q.size() > 0) ? hs_q[0] : 32'hFFFF_FFFF, 32'h0000_0100);
    dly_min = 0; dly_max = 0;

    wait_for_valid(1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0040);
    chk("redir_hold_req", {31'd0, bus.imem_req}, 32'd1);
    chk("redir_hold_addr", bus.imem_addr, 32'h0000_0040);
    chk("redir_hold_valid", {31'd0, IF_valid}, 32'd0);

    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    chk("rst_wait_addr", bus.imem_addr, RESET_PC);
    chk("rst_wait_req", {31'd0, bus.imem_req}, 32'd1);
    chk("rst_wait_valid", {31'd0, IF_valid}, 32'd0);
    chk("rst_wait_busy", {31'd0, fetch_busy}, 32'd1);

    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    wait_for_valid(1'b0);
    chk("wrap_pc_4", IF_pc_4, 32'h0000_0000);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    wait_for_fetch();
    chk("wrap_fetch", (hs_q.size() > 0) ? hs_q[0] : 32'hFFFF_FFFF, 32'h0000_0000);

`ifdef IF_ALIGN_CHECK_EN
    step(1'b0, 1'b0, 1'b1, 32'h0000_0102);
    chk("align_err", {31'd0, if_addr_err}, 32'd1);
    repeat (5) begin
      step(1'b0, 1'b0, 1'b0, 32'd0);
      chk("align_no_req", {31'd0, bus.imem_req}, 32'd0);
    end
    step(1'b0, 1'b0, 1'b1, 32'h0000_0200);
    chk("align_clear", {31'd0, if_addr_err}, 32'd0);
    chk("align_resume", bus.imem_addr, 32'h0000_0200);
`endif

    rdy_pct = 70; dly_min = 0; dly_max = 3;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(3))
        0:       t = 32'hFFFF_FFF8;
        1:       t = $urandom & 32'h0000_0FFF;
        2:       t = $urandom;
        default: t = 32'h0000_0100;
      endcase
      step($urandom_range(299) == 0, $urandom_range(3) == 0, $urandom_range(9) == 0, t);
    end
    chk("progress", {31'd0, consumed > 100}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
